// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// fifo_wr_arbiter : round-robin arbiter sharing one sync FIFO write port
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      fifo_full_i,
  output logic                      fifo_wr_en_o,
  output logic [DATA_W-1:0]         fifo_data_o,
  output logic [ID_W-1:0]           grant_id_o,
  output logic                      busy_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] last_q,  last_d;
  logic [3:0]      cnt_q,   cnt_d;

  logic [DATA_W-1:0] slice [NUM_REQ];
  logic              beat;
  logic              rel;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign slice[gi] = req_data_i[gi*DATA_W +: DATA_W];
  end

  // Search starts one past base and wraps, so base itself is checked last.
  function automatic logic [ID_W-1:0] rr_pick(input logic [ID_W-1:0] base,
                                              input logic [NUM_REQ-1:0] v);
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] win;
    logic            found;
    idx   = base;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
      if (!found && v[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign beat = (state_q == S_GRANT) & req_valid_i[owner_q] & ~fifo_full_i;
  assign rel  = (state_q == S_GRANT) &
                (~req_valid_i[owner_q] | (beat & ((cnt_q + 4'd1) == 4'(MAX_BURST))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req_valid_i) begin
          state_d = S_GRANT;
          owner_d = rr_pick(last_q, req_valid_i);
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (rel) begin
          last_d = owner_q;
          cnt_d  = '0;
          if (|req_valid_i) begin
            owner_d = rr_pick(owner_q, req_valid_i);
          end else begin
            state_d = S_IDLE;
            owner_d = '0;
          end
        end else if (beat) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = '0;
    fifo_wr_en_o = 1'b0;
    fifo_data_o  = '0;
    grant_id_o   = '0;
    busy_o       = 1'b0;
    if (state_q == S_GRANT) begin
      req_ready_o  = {{(NUM_REQ-1){1'b0}}, ~fifo_full_i} << owner_q;
      fifo_wr_en_o = beat;
      fifo_data_o  = slice[owner_q];
      grant_id_o   = owner_q;
      busy_o       = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// tb_fifo_wr_arbiter : scoreboard bench for fifo_wr_arbiter (4 req, burst 4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid_i;
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0]   req_ready_o;
  logic            fifo_full_i;
  logic            fifo_wr_en_o;
  logic [DW-1:0]   fifo_data_o;
  logic [1:0]      grant_id_o;
  logic            busy_o;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .fifo_full_i  (fifo_full_i),
    .fifo_wr_en_o (fifo_wr_en_o),
    .fifo_data_o  (fifo_data_o),
    .grant_id_o   (grant_id_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          rem [NR];
  int          seq [NR];
  logic [7:0]  base [NR];
  logic [15:0] exp_q [$];
  int          cyc = 0;
  int          first_wr = -1;
  int          last_wr  = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dat(input int i, input int n);
    return base[i] + 8'(n * 17);
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid_i[i]          = (rem[i] > 0);
      req_data_i[i*DW +: DW]  = (rem[i] > 0) ? dat(i, seq[i]) : 8'h00;
    end
  endtask

  task automatic push(input int i, input int n0, input int cnt);
    for (int k = 0; k < cnt; k++) exp_q.push_back({8'(i), dat(i, n0 + k)});
  endtask

  // Sample at the falling edge; requester state advances just after the rising edge.
  task automatic tick();
    logic [NR-1:0] hs;
    logic [15:0]   e;
    @(negedge clk);
    if (fifo_full_i) chk("wr_while_full", fifo_wr_en_o, 0);
    if (fifo_wr_en_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", fifo_data_o, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_id", grant_id_o, e[15:8]);
        chk("wr_data", fifo_data_o, e[7:0]);
      end
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end
    hs = req_valid_i & req_ready_o;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) begin
        rem[i]--;
        seq[i]++;
      end
    end
    drive();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, fifo_wr_en_o, 0);
    chk({tag, "_ready"}, req_ready_o, 0);
    chk({tag, "_data"},  fifo_data_o, 0);
    chk({tag, "_gid"},   grant_id_o, 0);
    chk({tag, "_busy"},  busy_o, 0);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    fifo_full_i = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rem[i]  = 0;
      seq[i]  = 0;
      base[i] = 8'(i * 64 + 1);
    end
    exp_q.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n    = 1'b1;
    first_wr = -1;
    last_wr  = -1;
  endtask

  task automatic drain(input string tag, input int maxc);
    int c = 0;
    while (exp_q.size() > 0 && c < maxc) begin
      tick();
      c++;
    end
    repeat (3) tick();
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_idle"}, busy_o, 0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fifo_full_i = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;

    // Single requester: idle cycle, three writes, back to idle.
    do_reset();
    base[2] = 8'h11;
    rem[2]  = 3;
    push(2, 0, 3);
    drive();
    #1;
    chk_zero("arb_cycle");
    drain("single", 20);
    chk("single_span", last_wr - first_wr + 1, 3);

    // Two requesters alternate in bursts of MB with no bubble.
    do_reset();
    rem[0] = 12;
    rem[1] = 12;
    for (int b = 0; b < 3; b++) begin
      push(0, b * MB, MB);
      push(1, b * MB, MB);
    end
    drive();
    drain("burst", 60);
    chk("burst_span", last_wr - first_wr + 1, 24);

    // All four requesters: round-robin order 0,1,2,3.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      rem[i] = MB;
      push(i, 0, MB);
    end
    drive();
    drain("rr", 40);
    chk("rr_span", last_wr - first_wr + 1, 16);

    // Backpressure mid-burst of req 3; req 0 arrives during the stall.
    do_reset();
    rem[3] = 6;
    push(3, 0, 4);
    push(0, 0, 4);
    push(3, 4, 2);
    drive();
    repeat (3) tick();
    fifo_full_i = 1'b1;
    rem[0] = 4;
    drive();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_wr_en", fifo_wr_en_o, 0);
      chk("stall_ready", req_ready_o, 0);
      chk("stall_busy",  busy_o, 1);
      chk("stall_gid",   grant_id_o, 3);
      tick();
    end
    fifo_full_i = 1'b0;
    drain("stall", 40);

    // Sole requester is re-granted back-to-back across burst boundaries.
    do_reset();
    rem[1] = 10;
    push(1, 0, 10);
    drive();
    drain("sole", 30);
    chk("sole_span", last_wr - first_wr + 1, 10);

    // Reset mid-burst, then requester 0 gets first priority again.
    do_reset();
    rem[0] = 4;
    push(0, 0, 2);
    drive();
    repeat (3) tick();
    chk("pre_rst_pending", exp_q.size(), 0);
    chk("pre_rst_busy", busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    rem[1] = 4;
    drive();
    repeat (2) tick();
    rst_n = 1'b1;
    push(0, 2, 2);
    push(1, 0, 4);
    drain("post_rst", 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
